// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for the five-stage pipeline. Tracks the
//   destination register and remaining result latency (Tnew) of the
//   instructions in E, M and W, and produces the D-stage stall/E-stage bubble
//   plus the select codes for the 3-to-1 forwarding muxes in D and E.
//   Select codes: 0 = register file / native value, 1 = from M, 2 = from W.
//
// Ports
//   clk, reset            pipeline clock, synchronous active-high reset
//   D_rs, D_rt            source register fields of the D instruction
//   D_use_rs, D_use_rt    D instruction actually reads that source
//   D_tuse_rs, D_tuse_rt  cycles until the source is consumed (0 = D, 1 = E)
//   D_dst, D_tnew         destination (0 = none) and result latency from E
//   stall                 hold PC and F/D, bubble into E
//   fwd_D_rs, fwd_D_rt    D-stage forwarding selects
//   fwd_E_rs, fwd_E_rt    E-stage forwarding selects
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_use_rs,
  input  logic       D_use_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  output logic       stall,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt
);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_M  = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;

  logic [4:0] E_rs, E_rt, E_dst;
  logic [1:0] E_tnew;
  logic [4:0] M_dst;
  logic [1:0] M_tnew;
  logic [4:0] W_dst;

  // Latency countdown saturates at zero so a ready result stays ready.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A consumer must wait while any in-flight producer of its source still
  // needs more cycles than the consumer can afford (Tnew > Tuse).
  function automatic logic src_stall(input logic       use_src,
                                     input logic [4:0] a,
                                     input logic [1:0] tuse);
    logic hit_e, hit_m;
    hit_e = (E_dst == a) && (E_tnew > tuse);
    hit_m = (M_dst == a) && (M_tnew > tuse);
    return use_src && (a != 5'd0) && (hit_e || hit_m);
  endfunction

  // M is younger than W, so it is checked first. An M producer whose result
  // is not ready yet never forwards; the stall already held the consumer.
  function automatic logic [1:0] fwd_sel(input logic [4:0] a);
    if (a == 5'd0)                           return SEL_RF;
    else if ((M_dst == a) && (M_tnew == 2'd0)) return SEL_M;
    else if (W_dst == a)                     return SEL_W;
    else                                     return SEL_RF;
  endfunction

  assign stall    = src_stall(D_use_rs, D_rs, D_tuse_rs)
                  | src_stall(D_use_rt, D_rt, D_tuse_rt);
  assign fwd_D_rs = fwd_sel(D_rs);
  assign fwd_D_rt = fwd_sel(D_rt);
  assign fwd_E_rs = fwd_sel(E_rs);
  assign fwd_E_rt = fwd_sel(E_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      E_rs   <= 5'd0;
      E_rt   <= 5'd0;
      E_dst  <= 5'd0;
      E_tnew <= 2'd0;
      M_dst  <= 5'd0;
      M_tnew <= 2'd0;
      W_dst  <= 5'd0;
    end else begin
      // D -> E boundary: a stalled D instruction is replaced by a bubble
      if (stall) begin
        E_rs   <= 5'd0;
        E_rt   <= 5'd0;
        E_dst  <= 5'd0;
        E_tnew <= 2'd0;
      end else begin
        E_rs   <= D_rs;
        E_rt   <= D_rt;
        E_dst  <= D_dst;
        E_tnew <= D_tnew;
      end
      // E -> M boundary
      M_dst  <= E_dst;
      M_tnew <= sat_dec(E_tnew);
      // M -> W boundary
      W_dst  <= M_dst;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage pipeline. It is the producer side of the forwarding multiplexers: it tracks destination registers and their remaining result latency (Tnew) through the E/M/W stages and generates the 2-bit select codes for the 3-to-1 forwarding muxes in D and E. It also generates the D-stage stall and the E-stage bubble. Select encoding is fixed as 0 = register-file/native value, 1 = forward from M, 2 = forward from W.

## Interface
- No parameters. Register address width is 5; Tnew/Tuse width is 2.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clears all stage state
- D_rs  in  5  rs field of the D-stage instruction
- D_rt  in  5  rt field of the D-stage instruction
- D_use_rs  in  1  D instruction reads rs
- D_use_rt  in  1  D instruction reads rt
- D_tuse_rs  in  2  cycles until rs is consumed (0 = in D, 1 = in E)
- D_tuse_rt  in  2  same for rt
- D_dst  in  5  destination register of the D instruction (0 = none)
- D_tnew  in  2  cycles after entering E until the result exists (ALU = 1, load = 2, link = 0)
- stall  out  1  hold PC and the F/D register; bubble into E
- fwd_D_rs  out  2  select for the D-stage rs mux
- fwd_D_rt  out  2  select for the D-stage rt mux
- fwd_E_rs  out  2  select for the E-stage rs mux
- fwd_E_rt  out  2  select for the E-stage rt mux

## Operation
- State registers: E_rs, E_rt, E_dst, E_tnew; M_dst, M_tnew; W_dst. After reset all are 0, so every output is 0.
- Every rising edge (reset low):
  - If stall = 1, E receives a bubble: E_rs, E_rt, E_dst and E_tnew are all 0.
  - Otherwise E receives D_rs, D_rt, D_dst and D_tnew.
  - M_dst <= E_dst.
  - M_tnew <= (E_tnew == 0) ? 0 : E_tnew - 1. The decrement saturates at 0 and never wraps.
  - W_dst <= M_dst. A W-stage result is always ready.
- Stall is combinational. For src in {rs, rt}, stall_src = D_use_src and D_src != 0 and at least one of:
  - E_dst == D_src and E_tnew > D_tuse_src
  - M_dst == D_src and M_tnew > D_tuse_src

  stall = stall_rs OR stall_rt.
- The D-stage selects are combinational, evaluated per operand address a (D_rs or D_rt):
  - a == 0 gives 0.
  - Otherwise, M_dst == a and M_tnew == 0 gives 1.
  - Otherwise, W_dst == a gives 2.
  - Otherwise 0.
- The E-stage selects use the same rule on E_rs and E_rt.
- Priority: when M and W hold the same register, M wins because it is the younger instruction.
- A match against M where M_tnew != 0 never forwards. In that case the stall logic already blocked the consumer.
- Register 0 never stalls and never forwards, even if D_dst = 0 is pipelined.
- The fwd_* outputs do not depend on stall.

## Timing
- Selects and stall are valid in the same cycle as their inputs. There is no internal latency on outputs.
- Stage state advances one stage per clock. A D instruction reaches E, M and W on edges 1, 2 and 3 after it is accepted.
- A stall lasts until the producer's decremented Tnew is <= Tuse. A load (Tnew 2) followed by a Tuse-0 consumer gives 2 stall cycles if adjacent and 1 if one instruction apart.
- Reset mid-operation: the next edge clears all stage state. stall and all selects read 0 from that cycle onward until new instructions enter.
- Simultaneous reset and stall: reset wins.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary D inputs -> stall = 0 and all fwd_* = 0 in the cycle after the reset edge.
- ALU back-to-back:
  - Stimulus: issue D_dst = 8, D_tnew = 1. Next cycle issue D_rs = 8, D_use_rs = 1, D_tuse_rs = 1.
  - Response: stall = 0. One edge later fwd_E_rs = 1. One further edge (no new writer to 8) fwd_E_rs = 2.
- Load-use:
  - Stimulus: issue D_dst = 9, D_tnew = 2. Next cycle issue D_rt = 9, D_use_rt = 1, D_tuse_rt = 0.
  - Response: stall = 1 for exactly 2 cycles, then fwd_D_rt = 2 with stall = 0. Bubbles are visible as E_dst = 0.
- M/W priority: two consecutive writers to register 5 (Tnew 1 each), then a reader of 5 in E -> fwd_E_rs = 1, not 2.
- Register zero: writer with D_dst = 0, D_tnew = 2, followed by a reader with D_rs = 0, D_tuse_rs = 0 -> stall = 0 and fwd_D_rs = 0 throughout.
- Reset during stall: load-use stall active, reset pulsed for 1 cycle -> stall drops to 0 on the cycle after the reset edge and the pending producer is discarded.
